// File: rtl/pipelined_popcount_acc.sv
// Pipelined ones-counter: a 3:2 counter layer feeds LAT-1 register stages and a final
// stage that either reports the per-beat count or accumulates it over a packet with saturation.
module pipelined_popcount_acc #(
    parameter int N     = 15,
    parameter int LAT   = 2,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_mode,
    output logic             out_ovf
);
    localparam int G  = (N + 2) / 3;
    localparam int PW = 2 * G;

    generate
        if (N < 3 || N > 64) begin : g_bad_n
            $error("pipelined_popcount_acc: N must be in 3..64");
        end
        if (LAT < 1 || LAT > 4) begin : g_bad_lat
            $error("pipelined_popcount_acc: LAT must be in 1..4");
        end
        if (ACC_W < $clog2(N + 1)) begin : g_bad_acc_w
            $error("pipelined_popcount_acc: ACC_W too narrow for N");
        end
    endgenerate

    // Handshake: a beat moves on in_valid & in_ready, a result on out_valid & out_ready.
    // A held result (out_valid & ~out_ready) freezes every stage and deasserts in_ready.
    logic stall;
    logic accept;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    function automatic logic [1:0] csa3(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    logic [3*G-1:0] padded;
    logic [PW-1:0]  fa_vec;
    assign padded = (3*G)'(in_data);

    always_comb begin
        fa_vec = '0;
        for (int g = 0; g < G; g++) begin
            fa_vec[2*g +: 2] = csa3(padded[3*g], padded[3*g+1], padded[3*g+2]);
        end
    end

    logic          fin_vld;
    logic          fin_mode;
    logic          fin_last;
    logic [PW-1:0] fin_part;

    generate
        if (LAT == 1) begin : g_direct
            assign fin_vld  = accept;
            assign fin_mode = in_mode;
            assign fin_last = in_last;
            assign fin_part = fa_vec;
        end else begin : g_pipe
            localparam int S = LAT - 1;
            logic          st_vld  [S];
            logic          st_mode [S];
            logic          st_last [S];
            logic [PW-1:0] st_part [S];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < S; i++) begin
                        st_vld[i]  <= 1'b0;
                        st_mode[i] <= 1'b0;
                        st_last[i] <= 1'b0;
                        st_part[i] <= '0;
                    end
                end else if (!stall) begin
                    st_vld[0]  <= accept;
                    st_mode[0] <= in_mode;
                    st_last[0] <= in_last;
                    st_part[0] <= fa_vec;
                    for (int i = 1; i < S; i++) begin
                        st_vld[i]  <= st_vld[i-1];
                        st_mode[i] <= st_mode[i-1];
                        st_last[i] <= st_last[i-1];
                        st_part[i] <= st_part[i-1];
                    end
                end
            end

            assign fin_vld  = st_vld[S-1];
            assign fin_mode = st_mode[S-1];
            assign fin_last = st_last[S-1];
            assign fin_part = st_part[S-1];
        end
    endgenerate

    logic [ACC_W-1:0] pc;
    always_comb begin
        pc = '0;
        for (int g = 0; g < G; g++) begin
            pc = pc + ACC_W'(fin_part[2*g +: 2]);
        end
    end

    logic [ACC_W-1:0] acc;
    logic             ovf_flag;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sat_sum;
    logic             ovf_next;

    // Adding non-negative counts is monotonic, so clamping each step gives the clamped total.
    assign sum      = {1'b0, acc} + {1'b0, pc};
    assign sat_sum  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    assign ovf_next = ovf_flag | sum[ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_mode  <= 1'b0;
            out_ovf   <= 1'b0;
            acc       <= '0;
            ovf_flag  <= 1'b0;
        end else if (!stall) begin
            out_valid <= 1'b0;
            if (fin_vld) begin
                if (!fin_mode) begin
                    out_valid <= 1'b1;
                    out_count <= pc;
                    out_mode  <= 1'b0;
                    out_ovf   <= 1'b0;
                end else if (fin_last) begin
                    out_valid <= 1'b1;
                    out_count <= sat_sum;
                    out_mode  <= 1'b1;
                    out_ovf   <= ovf_next;
                    acc       <= '0;
                    ovf_flag  <= 1'b0;
                end else begin
                    acc      <= sat_sum;
                    ovf_flag <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_popcount_acc.sv
// Bench for pipelined_popcount_acc: a 16-bit and a 4-bit accumulator instance share all inputs;
// directed table, backpressure, reset and random traffic are checked against a packet-level model.
module tb_pipelined_popcount_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_data;
    logic        in_mode;
    logic        in_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_count;
    logic        out_mode;
    logic        out_ovf;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [3:0]  s_out_count;
    logic        s_out_mode;
    logic        s_out_ovf;

    pipelined_popcount_acc #(.N(15), .LAT(2), .ACC_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_mode(out_mode), .out_ovf(out_ovf)
    );

    pipelined_popcount_acc #(.N(15), .LAT(2), .ACC_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_count(s_out_count),
        .out_mode(s_out_mode), .out_ovf(s_out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] data;
        logic        mode;
        logic        last;
        logic        has_out;
        logic [15:0] c16;
        logic        o16;
        logic [3:0]  c4;
        logic        o4;
    } vec_t;

    int total = 0;
    int bad = 0;
    int n_out = 0;
    int rdy_mode = 0;
    int pkt_total = 0;
    int mon_pc;
    logic [22:0] exp_q[$];
    logic [22:0] dir_q[$];
    logic [22:0] mon_e;
    logic [22:0] mon_d;
    vec_t vecs[15];

    function automatic logic [22:0] pack_exp(input logic m, input logic o16, input logic [15:0] c16,
                                             input logic o4, input logic [3:0] c4);
        return {m, o16, c16, o4, c4};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Scoreboard and reference model, sampled mid-cycle ahead of the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            dir_q.delete();
            pkt_total = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_output: got count %0d expected no output", out_count);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("model_res16", {13'd0, out_mode, out_ovf, out_count},
                          {13'd0, mon_e[22], mon_e[21], mon_e[20:5]});
                    check("model_res4", {26'd0, s_out_mode, s_out_ovf, s_out_count},
                          {26'd0, mon_e[22], mon_e[4], mon_e[3:0]});
                end
                if (dir_q.size() != 0) begin
                    mon_d = dir_q.pop_front();
                    check("directed_res16", {13'd0, out_mode, out_ovf, out_count},
                          {13'd0, mon_d[22], mon_d[21], mon_d[20:5]});
                    check("directed_res4", {26'd0, s_out_mode, s_out_ovf, s_out_count},
                          {26'd0, mon_d[22], mon_d[4], mon_d[3:0]});
                end
            end
            if (in_valid && in_ready) begin
                mon_pc = $countones(in_data);
                if (!in_mode) begin
                    exp_q.push_back(pack_exp(1'b0, 1'b0, 16'(mon_pc), 1'b0, 4'(mon_pc)));
                end else begin
                    pkt_total += mon_pc;
                    if (in_last) begin
                        exp_q.push_back(pack_exp(1'b1,
                            pkt_total > 65535, (pkt_total > 65535) ? 16'hFFFF : 16'(pkt_total),
                            pkt_total > 15,    (pkt_total > 15)    ? 4'hF     : 4'(pkt_total)));
                        pkt_total = 0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [14:0] d, input logic m, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 15'($urandom);
        in_mode  = 1'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        int w;
        vecs[0]  = '{15'h0000, 1'b0, 1'b0, 1'b1, 16'd0,  1'b0, 4'd0,  1'b0};
        vecs[1]  = '{15'h7FFF, 1'b0, 1'b0, 1'b1, 16'd15, 1'b0, 4'd15, 1'b0};
        vecs[2]  = '{15'h5555, 1'b0, 1'b0, 1'b1, 16'd8,  1'b0, 4'd8,  1'b0};
        vecs[3]  = '{15'h000F, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 4'd0,  1'b0};
        vecs[4]  = '{15'h00FF, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 4'd0,  1'b0};
        vecs[5]  = '{15'h7FFF, 1'b1, 1'b1, 1'b1, 16'd27, 1'b0, 4'd15, 1'b1};
        vecs[6]  = '{15'h0003, 1'b1, 1'b1, 1'b1, 16'd2,  1'b0, 4'd2,  1'b0};
        vecs[7]  = '{15'h7FFF, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 4'd0,  1'b0};
        vecs[8]  = '{15'h0001, 1'b1, 1'b1, 1'b1, 16'd16, 1'b0, 4'd15, 1'b1};
        vecs[9]  = '{15'h0001, 1'b1, 1'b1, 1'b1, 16'd1,  1'b0, 4'd1,  1'b0};
        vecs[10] = '{15'h0007, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 4'd0,  1'b0};
        vecs[11] = '{15'h0003, 1'b0, 1'b0, 1'b1, 16'd2,  1'b0, 4'd2,  1'b0};
        vecs[12] = '{15'h0001, 1'b1, 1'b1, 1'b1, 16'd4,  1'b0, 4'd4,  1'b0};
        vecs[13] = '{15'h1234, 1'b0, 1'b1, 1'b1, 16'd5,  1'b0, 4'd5,  1'b0};
        vecs[14] = '{15'h6AAA, 1'b0, 1'b0, 1'b1, 16'd8,  1'b0, 4'd8,  1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_mode  = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_mode_ovf", {out_mode, out_ovf}, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sat_state", {s_in_ready, s_out_valid, s_out_count}, 6'b100000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Latency: accepted at the end of cycle 0, visible in cycle LAT=2.
        dir_q.push_back(pack_exp(1'b0, 1'b0, 16'd0, 1'b0, 4'd0));
        send(15'h7FFF, 1'b0, 1'b0);
        dir_q.pop_back();
        dir_q.push_back(pack_exp(1'b0, 1'b0, 16'd15, 1'b0, 4'd15));
        @(negedge clk);
        check("lat_cycle1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_cycle2_valid", out_valid, 1);
        check("lat_cycle2_count", out_count, 15);
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].has_out)
                dir_q.push_back(pack_exp(vecs[i].mode, vecs[i].o16, vecs[i].c16, vecs[i].o4, vecs[i].c4));
            send(vecs[i].data, vecs[i].mode, vecs[i].last);
        end
        drain();
        check("table_dir_empty", dir_q.size(), 0);

        // Backpressure: hold out_ready low for 3 cycles once the first result appears.
        n0 = n_out;
        fork
            begin
                repeat (4) begin
                    dir_q.push_back(pack_exp(1'b0, 1'b0, 16'd1, 1'b0, 4'd1));
                    send(15'h0001, 1'b0, 1'b0);
                end
            end
            begin
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                check("bp_out_valid_seen", out_valid, 1);
                rdy_mode = 1;
                @(posedge clk);
                #2;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready_low", in_ready, 0);
                    check("bp_held_result", {out_valid, out_count}, {1'b1, 16'd1});
                end
                rdy_mode = 0;
            end
        join
        drain();
        check("bp_output_count", n_out - n0, 4);

        // Reset mid-packet with one result held and one beat in the pipeline.
        rdy_mode = 1;
        @(posedge clk);
        #1;
        send(15'h0003, 1'b1, 1'b0);
        send(15'h0001, 1'b0, 1'b0);
        send(15'h0003, 1'b1, 1'b0);
        @(negedge clk);
        check("rstmid_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid_drop", out_valid, 0);
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_count_clr", out_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        dir_q.push_back(pack_exp(1'b1, 1'b0, 16'd1, 1'b0, 4'd1));
        send(15'h0001, 1'b1, 1'b1);
        drain();
        check("rstmid_dir_empty", dir_q.size(), 0);

        rdy_mode = 2;
        for (int i = 0; i < 500; i++) begin
            send(15'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        send(15'($urandom), 1'b1, 1'b1);
        rdy_mode = 0;
        drain();
        check("final_dir_empty", dir_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
